// File: rtl/dmem_ctrl_if.sv
// ============================================================================
// dmem_ctrl_if : CPU request/response and MMIO bus bundle for dmem_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mmio_sel;
  logic        mmio_we;
  logic [3:0]  mmio_be;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_ack;

  // Environment side: the CPU issuing requests plus the MMIO target.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mmio_rdata, mmio_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mmio_sel, mmio_we, mmio_be, mmio_addr, mmio_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mmio_rdata, mmio_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mmio_sel, mmio_we, mmio_be, mmio_addr, mmio_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : data-memory controller, internal RAM plus MMIO window
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
  parameter int          RAM_AW       = 14,
  parameter logic [15:0] MMIO_HI      = 16'hFFFF,
  parameter int          MMIO_TIMEOUT = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  dmem_ctrl_if.slave  bus
);

  localparam int             TW         = $clog2(MMIO_TIMEOUT + 1);
  localparam logic [TW-1:0]  c_TMO_LAST = TW'(MMIO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MMIO = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [1:0]          r_size;
  logic [1:0]          r_off;
  logic                r_uns;
  logic [TW-1:0]       r_tmo;
  logic                r_ram_load;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;
  logic                r_mmio_sel;
  logic                r_mmio_we;
  logic [3:0]          r_mmio_be;
  logic [31:0]         r_mmio_addr;
  logic [31:0]         r_mmio_wdata;
  logic [31:0]         r_ram_q;
  logic [31:0]         r_mem [0:(1<<RAM_AW)-1];

  logic                w_accept;
  logic                w_is_ram;
  logic                w_is_mmio;
  logic                w_misalign;
  logic                w_fault;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata_rep;
  logic [RAM_AW-1:0]   w_idx;

  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign w_accept   = bus.req_valid && (r_state == IDLE);
  assign w_is_ram   = (bus.req_addr >> (RAM_AW + 2)) == 32'd0;
  assign w_is_mmio  = bus.req_addr[31:16] == MMIO_HI;
  assign w_misalign = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign w_fault    = w_misalign || !(w_is_ram || w_is_mmio);
  assign w_idx      = bus.req_addr[RAM_AW+1:2];

  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_be        = 4'b0001 << bus.req_addr[1:0];
        w_wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_ram && !w_fault) begin
      if (bus.req_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end else begin
        r_ram_q <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_uns        <= 1'b0;
      r_tmo        <= '0;
      r_ram_load   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mmio_sel   <= 1'b0;
      r_mmio_we    <= 1'b0;
      r_mmio_be    <= 4'b0000;
      r_mmio_addr  <= 32'd0;
      r_mmio_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we   <= bus.req_we;
            r_size <= bus.req_size;
            r_off  <= bus.req_addr[1:0];
            r_uns  <= bus.req_unsigned;
            if (w_fault) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= RESP;
            end else if (w_is_ram) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= 32'd0;
              r_ram_load   <= !bus.req_we;
              r_state      <= RESP;
            end else begin
              r_mmio_sel   <= 1'b1;
              r_mmio_we    <= bus.req_we;
              r_mmio_be    <= w_be;
              r_mmio_addr  <= bus.req_addr;
              r_mmio_wdata <= w_wdata_rep;
              r_tmo        <= '0;
              r_state      <= MMIO;
            end
          end
        end
        MMIO: begin
          // An ack arriving on the final timeout cycle still completes normally.
          if (bus.mmio_ack) begin
            r_mmio_sel   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? 32'd0 : f_extract(bus.mmio_rdata, r_size, r_off, r_uns);
            r_state      <= RESP;
          end else if (r_tmo == c_TMO_LAST) begin
            r_mmio_sel   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_state      <= RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_ram_load   <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  // RAM loads are extracted from the synchronous-read register in the response cycle.
  assign bus.resp_rdata = r_ram_load ? f_extract(r_ram_q, r_size, r_off, r_uns) : r_resp_rdata;
  assign bus.mmio_sel   = r_mmio_sel;
  assign bus.mmio_we    = r_mmio_we;
  assign bus.mmio_be    = r_mmio_be;
  assign bus.mmio_addr  = r_mmio_addr;
  assign bus.mmio_wdata = r_mmio_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : randomized self-checking bench with a byte-array memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if bus ();

  dmem_ctrl #(
    .RAM_AW      (14),
    .MMIO_HI     (16'hFFFF),
    .MMIO_TIMEOUT(16)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] ref_mem [int];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input logic uns);
    if (n == 1) return uns ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    if (n == 2) return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    return raw;
  endfunction

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] mrd, input string tag);
    int          n, sel_cnt, lat, exp_sel;
    logic        flt, mm, ram, exp_err, got_resp, unstable;
    logic [31:0] raw, exp_rd, exp_wd;
    logic [3:0]  exp_be, be0;
    logic [31:0] wd0, ad0;
    logic        we0;
    n   = nbytes(sz);
    flt = (n == 0) || (a % n != 0) || !(a < 32'h0001_0000 || a[31:16] == 16'hFFFF);
    mm  = !flt && a[31:16] == 16'hFFFF;
    ram = !flt && !mm;
    exp_sel = !mm ? 0 : ((ack_dly >= 1 && ack_dly <= 16) ? ack_dly : 16);
    exp_err = flt || (mm && !(ack_dly >= 1 && ack_dly <= 16));
    raw = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (ram) raw[8*i +: 8] = ref_mem.exists(int'(a + i)) ? ref_mem[int'(a + i)] : 8'h00;
      else     raw[8*i +: 8] = mrd[8*((a[1:0] + i) % 4) +: 8];
    end
    exp_rd = (exp_err || we) ? 32'd0 : extend(raw, n, uns);
    exp_be = 4'(((1 << n) - 1) << a[1:0]);
    exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    if (ram && we) for (int i = 0; i < n; i++) ref_mem[int'(a + i)] = wd[8*i +: 8];

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = 2'($urandom);
    bus.req_unsigned = ~uns; bus.req_addr = $urandom; bus.req_wdata = $urandom;

    sel_cnt = 0; lat = 0; got_resp = 1'b0; unstable = 1'b0;
    be0 = '0; wd0 = '0; ad0 = '0; we0 = 1'b0;
    while (lat < 100) begin
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        break;
      end
      if (bus.mmio_sel) begin
        sel_cnt++;
        if (sel_cnt == 1) begin
          be0 = bus.mmio_be; wd0 = bus.mmio_wdata; ad0 = bus.mmio_addr; we0 = bus.mmio_we;
        end else if (bus.mmio_be !== be0 || bus.mmio_wdata !== wd0 ||
                     bus.mmio_addr !== ad0 || bus.mmio_we !== we0) begin
          unstable = 1'b1;
        end
        if (sel_cnt == ack_dly) begin
          bus.mmio_rdata = mrd;
          bus.mmio_ack   = 1'b1;
        end
      end
      @(posedge clk); #1;
      bus.mmio_ack = 1'b0; bus.mmio_rdata = $urandom;
      lat++;
    end
    chk({tag, "_resp"}, 32'(got_resp), 32'd1);
    chk({tag, "_lat"}, lat, exp_sel);
    chk({tag, "_sel"}, sel_cnt, exp_sel);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_rd"}, bus.resp_rdata, exp_rd);
    last_rd = bus.resp_rdata;
    if (mm && sel_cnt > 0) begin
      chk({tag, "_be"}, 32'(be0), 32'(exp_be));
      chk({tag, "_wd"}, wd0, exp_wd);
      chk({tag, "_addr"}, ad0, a);
      chk({tag, "_mwe"}, 32'(we0), 32'(we));
      chk({tag, "_hold"}, 32'(unstable), 32'd0);
    end
    // A stray ack during the response cycle must be ignored.
    if ($urandom_range(0, 1) == 1) bus.mmio_ack = 1'b1;
    @(posedge clk); #1;
    bus.mmio_ack = 1'b0;
    chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r, n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mmio_rdata = '0; bus.mmio_ack = 1'b0;
    last_rd = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_sel", 32'(bus.mmio_sel), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mbe", 32'(bus.mmio_be), 32'd0);
    chk("rst_maddr", bus.mmio_addr, 32'd0);
    chk("rst_mwdata", bus.mmio_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    for (int k = 0; k < 64; k++) access(1'b1, 2'b10, 1'b0, 32'(4 * k), $urandom, 0, 0, "init_lo");
    for (int k = 0; k < 4; k++) access(1'b1, 2'b10, 1'b0, 32'h0000_FFF0 + 32'(4 * k), $urandom, 0, 0, "init_hi");

    access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 0, 0, "st_w10");
    access(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0, 0, "ld_bu13");
    chk("const_bu13", last_rd, 32'h0000_0011);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 0, 0, "ld_hs12");
    chk("const_hs12", last_rd, 32'h0000_1122);
    access(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 0, "st_w20");
    access(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0080, 0, 0, "st_b21");
    access(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0, 0, 0, "ld_bs21");
    chk("const_bs21", last_rd, 32'hFFFF_FF80);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 0, "ld_w20");
    chk("const_w20", last_rd, 32'h0000_8000);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 3, 32'h5A5A_5A5A, "misal_w");
    access(1'b0, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 3, 32'h5A5A_5A5A, "size11");
    access(1'b1, 2'b01, 1'b0, 32'hFFFF_0002, 32'h0000_BEEF, 3, 32'h0, "mmio_sth");
    access(1'b0, 2'b10, 1'b0, 32'hFFFF_0010, 32'h0, 0, 32'hDEAD_BEEF, "mmio_tmo");
    access(1'b0, 2'b10, 1'b0, 32'hFFFF_0010, 32'h0, 16, 32'hCAFE_F00D, "mmio_ack16");
    access(1'b0, 2'b10, 1'b0, 32'h1234_0000, 32'h0, 1, 32'h0, "unmapped");
    access(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 1, 32'h0, "ram_edge_out");
    access(1'b0, 2'b10, 1'b0, 32'h0000_FFFC, 32'h0, 0, 0, "ram_edge_in");
    access(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, 0, "alias_chk");

    // Reset in the middle of an MMIO wait.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_sel_before", 32'(bus.mmio_sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel", 32'(bus.mmio_sel), 32'd0);
    chk("mrst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mrst_maddr", bus.mmio_addr, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_valid_hold", 32'(bus.resp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst_noresp", 32'(bus.resp_valid), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 0, "post_rst_ld");
    chk("const_post_rst", last_rd, 32'h1122_3344);

    for (int k = 0; k < 150; k++) begin
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r <= 4)      a = 32'($urandom_range(0, 255));
      else if (r == 5) a = 32'($urandom_range(32'hFFF0, 32'hFFFF));
      else if (r <= 7) a = {16'hFFFF, 16'($urandom)};
      else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0001_0000;
          1:       a = 32'h1234_0000;
          2:       a = 32'hFFFE_FFFC;
          default: a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
        endcase
      end
      n = nbytes(sz);
      if (n != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      access(1'($urandom), sz, 1'($urandom), a, $urandom,
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6), $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, word-address width of internal data RAM (2^RAM_AW 32-bit words).
REQ-002 SHALL have parameter MMIO_HI, default 16'hFFFF, value of addr[31:16] selecting the MMIO region.
REQ-003 SHALL have parameter MMIO_TIMEOUT, default 16, maximum cycles to wait for mmio_ack.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU access request.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-015 resp_err  output  1  access faulted, valid with resp_valid.
REQ-016 mmio_sel, mmio_we  output  1 each  MMIO access strobe and direction.
REQ-017 mmio_be  output  4  MMIO byte enables.
REQ-018 mmio_addr, mmio_wdata  output  32 each  MMIO address and lane-aligned data.
REQ-019 mmio_rdata  input  32  MMIO read data, sampled with mmio_ack.
REQ-020 mmio_ack  input  1  MMIO access complete.

Function
REQ-021 SHALL implement FSM states IDLE, MMIO, RESP; req_ready = 1 only in IDLE; request accepted on req_valid && req_ready.
REQ-022 Decode at accept: RAM when addr[31:RAM_AW+2] == 0; MMIO when addr[31:16] == MMIO_HI; otherwise unmapped.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or req_size=11 SHALL fault: no RAM write, no mmio_sel, RESP next cycle with resp_err=1.
REQ-024 Unmapped address SHALL fault identically to REQ-023.
REQ-025 Byte enables: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 or 4'b1100 by addr[1]; word -> 4'b1111.
REQ-026 Store data SHALL be replicated across lanes (byte x4, half x2) before RAM or MMIO write.
REQ-027 RAM store SHALL write enabled bytes of word addr[RAM_AW+1:2] on the accepting edge; FSM -> RESP; resp_valid next cycle, resp_err=0.
REQ-028 RAM load SHALL read synchronously on the accepting edge; FSM -> RESP; resp_rdata next cycle (latency 1).
REQ-029 Load extraction: select lane by addr[1:0]/addr[1], shift to bit 0, extend per req_unsigned; word loads unmodified.
REQ-030 MMIO access: FSM -> MMIO; mmio_sel, mmio_we, mmio_be, mmio_addr, mmio_wdata registered and held stable until ack or timeout.
REQ-031 In MMIO, mmio_ack SHALL capture mmio_rdata (extracted per REQ-029), deassert mmio_sel and go to RESP; ack in same cycle as timeout wins.
REQ-032 Timeout counter SHALL clear on MMIO entry; MMIO_TIMEOUT cycles without ack -> deassert mmio_sel, RESP with resp_err=1, resp_rdata=0.
REQ-033 mmio_ack outside MMIO state SHALL be ignored.
REQ-034 RESP SHALL assert resp_valid for exactly one cycle then return to IDLE; no response back-pressure; peak throughput one access per 2 cycles.
REQ-035 Request attributes SHALL be latched at accept; input changes afterwards do not affect the access.

Reset
REQ-036 rst_n low SHALL immediately force IDLE and clear req_ready-related state; outputs resp_valid, resp_err, mmio_sel, mmio_we = 0; resp_rdata, mmio_be, mmio_addr, mmio_wdata = 0; timeout counter = 0.
REQ-037 Reset mid-MMIO SHALL drop mmio_sel with no response; RAM contents SHALL NOT be cleared by reset.
REQ-038 After rst_n rises, req_ready SHALL be 1 on the first clock edge.

Verification
REQ-039 Store word 0x11223344 to 0x0000_0010, then load byte unsigned from 0x0000_0013 -> resp_rdata 0x00000011; load half signed from 0x0000_0012 -> 0x00001122.
REQ-040 Store byte 0x80 to 0x0000_0021 over prior word 0; load byte signed 0x21 -> 0xFFFFFF80, load word 0x20 -> 0x00008000.
REQ-041 Load word from 0x0000_0002 -> resp_err=1 next cycle, no RAM/MMIO activity; req_size=11 same.
REQ-042 Store half 0xBEEF to 0xFFFF_0002, mmio_ack after 3 cycles -> mmio_be 4'b1100, mmio_wdata 0xBEEFBEEF held 3 cycles, resp_valid one cycle later, resp_err=0.
REQ-043 MMIO load with no ack -> mmio_sel held 16 cycles, then resp_err=1, resp_rdata=0; access to 0x1234_0000 -> resp_err=1.
REQ-044 Assert rst_n low during MMIO wait -> mmio_sel=0 immediately, no resp_valid; prior RAM data still readable after reset.
